id_hazard_issue: RTL and testbench
==================================

// Module: id_hazard_issue
// PURPOSE
//  Parametrised issue/hazard controller for the decode stage. Tracks in-flight register writers across
//  FWD_DEPTH back-end stages (EX, MEM, WB, ...). Generates the operand forwarding selects for the decode stage.
//  Stalls decode on load-use hazards and injects bubbles into EX. Generalises fixed 2-bit EX/MEM/WB forwarding
//  to any depth and load latency, and adds a valid/ready handshake.
// PARAMETERS
//  AW        5  register address width (2**AW architectural registers; x0 hard-wired zero)
//  FWD_DEPTH 3  tracked back-end stages; index 0 = EX, 1 = MEM, 2 = WB
//  LOAD_LAT  2  load result forwardable only from tracker index >= LOAD_LAT-1 (LOAD_LAT=2: MEM onward)
//  SW        $clog2(FWD_DEPTH+1)  forwarding-select width (derived, not overridable)
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_i            in   1     asynchronous reset, active-low
//  id_valid_i       in   1     decode holds a valid instruction
//  id_ready_o       out  1     decode instruction accepted this cycle
//  id_flush_i       in   1     kill the decode instruction (branch/jump redirect)
//  id_rs1_i         in   AW    source 1 address
//  id_rs2_i         in   AW    source 2 address
//  id_rs1_used_i    in   1     instruction reads rs1
//  id_rs2_used_i    in   1     instruction reads rs2
//  id_rd_i          in   AW    destination address
//  id_we_i          in   1     instruction writes rd
//  id_is_load_i     in   1     instruction is a load
//  ex_ready_i       in   1     back-end advances this cycle; when low, all tracked stages hold
//  ex_valid_o       out  1     EX holds a valid (non-bubble) instruction (registered)
//  fwd_a_sel_o      out  SW    rs1 source: 0 = register file, k+1 = tracker stage k
//  fwd_b_sel_o      out  SW    rs2 source, same encoding
//  hazard_o         out  1     load-use stall active this cycle
//  perf_stall_cnt_o out  32    stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Tracker: FWD_DEPTH entries {valid, we, is_load, rd}, registered. Reset value of every entry: all zero.
//  - Match, per source: rs_used && rs != 0 && entry.valid && entry.we && entry.rd == rs.
//    The youngest (lowest index) match wins; fwd_sel = index+1. No match: fwd_sel = 0. Combinational.
//  - Hazard: the winning match has is_load && index < LOAD_LAT-1. Then fwd_sel = 0 and hazard_o = id_valid_i.
//    hazard_o is also 0 when id_flush_i is high (a flushed instruction never stalls).
//  - id_ready_o = ex_ready_i && !hazard_o (combinational; 1 out of reset when ex_ready_i = 1).
//  - fire = id_valid_i && id_ready_o && !id_flush_i.
//  - When ex_ready_i = 1: entries shift (k -> k+1; the oldest drops out).
//    Entry 0 <= decode fields with valid = fire; otherwise a bubble (all zero).
//  - When ex_ready_i = 0: the tracker holds. Flush still applies to decode only; tracked entries are never cleared by flush.
//  - ex_valid_o = entry0.valid; reset 0.
//  - A writer to x0 never matches. Both sources may match different stages in the same cycle.
//  - Reset asserted mid-operation: the tracker clears immediately, and so does the counter.
//    The first cycle after release behaves as an empty pipeline.
//  - Latency: the decode-to-EX entry takes 1 cycle. A load in EX stalls a dependent instruction for LOAD_LAT-1 cycles.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: perf_stall_cnt_o is a 32-bit counter.
//    It increments on every cycle with hazard_o=1 and saturates at 32'hFFFF_FFFF. Reset value 0.
//  Not defined: perf_stall_cnt_o is tied to 32'd0 and no counter flops exist.
// STRUCTURE
//  Shared package id_pkg: trk_entry_t struct; FWD_RF = 0 select constant.
//  Sub-module id_fwd_match: one source vs tracker -> {hit, sel, load_hazard}; instantiated twice (rs1, rs2).
//  Tracker shift register, handshake and counter live in the top module.
// TESTING
//  1 Issue "add x5" then "add x6,x5,x5" back-to-back, ex_ready_i=1 -> second: fwd_a_sel=fwd_b_sel=1, no stall.
//  2 Load to x7 fires, next instruction reads x7 (LOAD_LAT=2) -> hazard_o=1 and id_ready_o=0 for 1 cycle,
//    ex_valid_o=0 next cycle (bubble), then fwd_a_sel=2.
//  3 Writers to x3 in EX and in MEM, reader of x3 -> fwd_sel=1 (youngest wins); writer to x0 -> fwd_sel=0.
//  4 ex_ready_i=0 for 3 cycles with a pending load -> tracker frozen, id_ready_o=0, and ex_valid_o is held.
//    Resume -> shift continues.
//  5 id_flush_i during a load-use stall -> hazard_o=0, bubble issued, no stall counted.
//  6 Reset pulsed mid-stream -> ex_valid_o=0 and selects 0 immediately; with HAZARD_PERF_CNT_EN, the counter
//    reads 0 after reset and 4 after 4 stall cycles.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types for the decode-stage issue/hazard controller.
// The tracker entry keeps rd at a fixed maximum width so the struct is
// independent of the top-level AW parameter; AW must not exceed RD_W.
package id_pkg;

  // Widest register address the tracker can hold; narrower addresses are zero-extended.
  localparam int RD_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic            is_load;
    logic [RD_W-1:0] rd;
  } trk_entry_t;

endpackage

// File: rtl/id_fwd_match.sv
// Compares one decode source register against every tracked back-end stage.
// Produces the forwarding select for the youngest matching writer, or FWD_RF
// when there is no match or the youngest writer is a load whose data is not
// yet available (load_hazard).
module id_fwd_match
  import id_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int SW        = 2
) (
  input  logic                         used,
  input  logic [RD_W-1:0]              rs,
  input  trk_entry_t [FWD_DEPTH-1:0]   trk,
  output logic                         hit,
  output logic [SW-1:0]                sel,
  output logic                         load_hazard
);

  // Scan oldest to youngest so the lowest-index match overwrites older ones.
  always_comb begin
    hit         = 1'b0;
    sel         = SW'(FWD_RF);
    load_hazard = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (used && (rs != '0) && trk[k].valid && trk[k].we && (trk[k].rd == rs)) begin
        hit         = 1'b1;
        sel         = SW'(k + 1);
        load_hazard = trk[k].is_load && (k < LOAD_LAT - 1);
      end
    end
    if (load_hazard) sel = SW'(FWD_RF);
  end

endmodule

// File: rtl/id_hazard_issue.sv
// Decode-stage issue/hazard controller: tracks in-flight register writers over
// FWD_DEPTH back-end stages, generates operand forwarding selects, stalls on
// load-use hazards and injects bubbles into EX.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating 32-bit
// stall-cycle counter; without it perf_stall_cnt_o is constant zero.
module id_hazard_issue
  import id_pkg::*;
#(
  parameter  int AW        = 5,
  parameter  int FWD_DEPTH = 3,
  parameter  int LOAD_LAT  = 2,
  localparam int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  output logic          id_ready_o,
  input  logic          id_flush_i,
  input  logic [AW-1:0] id_rs1_i,
  input  logic [AW-1:0] id_rs2_i,
  input  logic          id_rs1_used_i,
  input  logic          id_rs2_used_i,
  input  logic [AW-1:0] id_rd_i,
  input  logic          id_we_i,
  input  logic          id_is_load_i,
  input  logic          ex_ready_i,
  output logic          ex_valid_o,
  output logic [SW-1:0] fwd_a_sel_o,
  output logic [SW-1:0] fwd_b_sel_o,
  output logic          hazard_o,
  output logic [31:0]   perf_stall_cnt_o
);

  trk_entry_t [FWD_DEPTH-1:0] trk;

  logic          hit_a, hit_b;
  logic          haz_a, haz_b;
  logic [SW-1:0] sel_a, sel_b;
  logic          hazard;
  logic          fire;

  id_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_a (
    .used        (id_rs1_used_i),
    .rs          (RD_W'(id_rs1_i)),
    .trk         (trk),
    .hit         (hit_a),
    .sel         (sel_a),
    .load_hazard (haz_a)
  );

  id_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_b (
    .used        (id_rs2_used_i),
    .rs          (RD_W'(id_rs2_i)),
    .trk         (trk),
    .hit         (hit_b),
    .sel         (sel_b),
    .load_hazard (haz_b)
  );

  // A flushed instruction is being killed anyway, so it never stalls decode.
  assign hazard = id_valid_i && !id_flush_i && ((hit_a && haz_a) || (hit_b && haz_b));
  assign fire   = id_valid_i && id_ready_o && !id_flush_i;

  assign hazard_o    = hazard;
  assign id_ready_o  = ex_ready_i && !hazard;
  assign ex_valid_o  = trk[0].valid;
  assign fwd_a_sel_o = sel_a;
  assign fwd_b_sel_o = sel_b;

  // Tracker shift register: advances with the back end, entry 0 takes the issued instruction or a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      trk <= '0;
    end else if (ex_ready_i) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) trk[k] <= trk[k-1];
      if (fire) begin
        trk[0] <= '{valid: 1'b1, we: id_we_i, is_load: id_is_load_i, rd: RD_W'(id_rd_i)};
      end else begin
        trk[0] <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles spent in a load-use stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_issue.sv
// Scoreboard bench for id_hazard_issue: the driver applies one directed vector
// per cycle and queues its hand-computed expectation; a monitor on the falling
// edge pops and compares each expectation against the DUT outputs.
module tb_id_hazard_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic        id_flush = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_rs1_used = 1'b0;
  logic        id_rs2_used = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_is_load = 1'b0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        hazard;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        exv;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        haz;
    logic        rdy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  id_hazard_issue #(.AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_valid_i       (id_valid),
    .id_ready_o       (id_ready),
    .id_flush_i       (id_flush),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_rs1_used_i    (id_rs1_used),
    .id_rs2_used_i    (id_rs2_used),
    .id_rd_i          (id_rd),
    .id_we_i          (id_we),
    .id_is_load_i     (id_is_load),
    .ex_ready_i       (ex_ready),
    .ex_valid_o       (ex_valid),
    .fwd_a_sel_o      (fwd_a_sel),
    .fwd_b_sel_o      (fwd_b_sel),
    .hazard_o         (hazard),
    .perf_stall_cnt_o (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "ex_valid",  32'(ex_valid),  32'(e.exv));
        chk(e.name, "fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
        chk(e.name, "fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
        chk(e.name, "hazard",    32'(hazard),    32'(e.haz));
        chk(e.name, "id_ready",  32'(id_ready),  32'(e.rdy));
`ifdef HAZARD_PERF_CNT_EN
        chk(e.name, "stall_cnt", perf_stall_cnt, e.cnt);
`else
        chk(e.name, "stall_cnt", perf_stall_cnt, 32'd0);
`endif
      end
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input string name,
                      input logic v, input logic fl,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic exr, input logic rstv,
                      input logic exv, input logic [1:0] a, input logic [1:0] b,
                      input logic haz, input logic rdy, input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rstv; id_valid = v; id_flush = fl;
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_is_load = ld; ex_ready = exr;
    e.name = name; e.exv = exv; e.a = a; e.b = b; e.haz = haz; e.rdy = rdy; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    fork
      monitor();
    join_none
    #12 rst = 1'b1;

    //    name        v  fl rs1 rs2 u1 u2 rd we ld exr rst  exv a  b  haz rdy cnt
    step("reset",     0, 0, 0,  0,  0, 0, 0, 0, 0, 1,  1,   0, 0, 0, 0,  1,  0);
    // back-to-back ALU dependency forwards from EX
    step("add_x5",    1, 0, 1,  2,  1, 1, 5, 1, 0, 1,  1,   0, 0, 0, 0,  1,  0);
    step("add_x6",    1, 0, 5,  5,  1, 1, 6, 1, 0, 1,  1,   1, 1, 1, 0,  1,  0);
    // load-use: one stall cycle, bubble, then forward from MEM
    step("ld_x7",     1, 0, 1,  0,  1, 0, 7, 1, 1, 1,  1,   1, 0, 0, 0,  1,  0);
    step("use_x7_st", 1, 0, 7,  6,  1, 1, 8, 1, 0, 1,  1,   1, 0, 2, 1,  0,  0);
    step("use_x7_go", 1, 0, 7,  6,  1, 1, 8, 1, 0, 1,  1,   0, 2, 3, 0,  1,  1);
    // two writers of x3: youngest wins; x0 never forwards
    step("wr_x3_a",   1, 0, 0,  0,  0, 0, 3, 1, 0, 1,  1,   1, 0, 0, 0,  1,  1);
    step("wr_x3_b",   1, 0, 0,  0,  0, 0, 3, 1, 0, 1,  1,   1, 0, 0, 0,  1,  1);
    step("rd_x3",     1, 0, 3,  3,  1, 1, 0, 1, 0, 1,  1,   1, 1, 1, 0,  1,  1);
    step("rd_x0",     1, 0, 0,  3,  1, 1, 0, 0, 0, 1,  1,   1, 0, 2, 0,  1,  1);
    // back end held for three cycles with a load in EX
    step("ld_x9",     1, 0, 0,  0,  0, 0, 9, 1, 1, 1,  1,   1, 0, 0, 0,  1,  1);
    step("hold_1",    1, 0, 9,  0,  1, 0,10, 1, 0, 0,  1,   1, 0, 0, 1,  0,  1);
    step("hold_2",    1, 0, 9,  0,  1, 0,10, 1, 0, 0,  1,   1, 0, 0, 1,  0,  2);
    step("hold_3",    1, 0, 9,  0,  1, 0,10, 1, 0, 0,  1,   1, 0, 0, 1,  0,  3);
    step("resume",    1, 0, 9,  0,  1, 0,10, 1, 0, 1,  1,   1, 0, 0, 1,  0,  4);
    step("use_x9",    1, 0, 9,  0,  1, 0,10, 1, 0, 1,  1,   0, 2, 0, 0,  1,  5);
    // flush during a load-use stall: no stall, bubble issued
    step("ld_x11",    1, 0, 0,  0,  0, 0,11, 1, 1, 1,  1,   1, 0, 0, 0,  1,  5);
    step("flush",     1, 1,11,  0,  1, 0,12, 1, 0, 1,  1,   1, 0, 0, 0,  1,  5);
    step("after_fl",  0, 0,11,  0,  1, 0, 0, 0, 0, 1,  1,   0, 2, 0, 0,  1,  5);
    // asynchronous reset mid-stream, then four counted stall cycles
    step("ld_x12",    1, 0, 0,  0,  0, 0,12, 1, 1, 1,  1,   0, 0, 0, 0,  1,  5);
    step("rst_mid",   1, 0,12,  0,  1, 0,13, 1, 0, 1,  0,   0, 0, 0, 0,  1,  0);
    step("post_rst",  0, 0,12,  0,  1, 0, 0, 0, 0, 1,  1,   0, 0, 0, 0,  1,  0);
    step("ld_x13",    1, 0, 0,  0,  0, 0,13, 1, 1, 1,  1,   0, 0, 0, 0,  1,  0);
    step("st_1",      1, 0,13,  0,  1, 0,14, 1, 0, 0,  1,   1, 0, 0, 1,  0,  0);
    step("st_2",      1, 0,13,  0,  1, 0,14, 1, 0, 0,  1,   1, 0, 0, 1,  0,  1);
    step("st_3",      1, 0,13,  0,  1, 0,14, 1, 0, 0,  1,   1, 0, 0, 1,  0,  2);
    step("st_4",      1, 0,13,  0,  1, 0,14, 1, 0, 0,  1,   1, 0, 0, 1,  0,  3);
    step("cnt_4",     0, 0, 0,  0,  0, 0, 0, 0, 0, 1,  1,   1, 0, 0, 0,  1,  4);
    step("bk_hold",   1, 0, 0,  0,  0, 0, 1, 1, 0, 0,  1,   0, 0, 0, 0,  0,  4);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
